logic_pipe: RTL and testbench

- Parametrised, handshaked successor to the two-input gate/flop datapath.
- Each lane combines two input words with a one-beat history of `pi1` using a run-time-selectable boolean function.
- Results are buffered in an output FIFO, together with the previous result.
- Sits between upstream stimulus logic and downstream consumers wherever a registered, flow-controlled logic stage is needed.

---
 rtl/logic_pipe_pkg.sv | 32 +++
 rtl/logic_pipe_if.sv | 39 +++
 rtl/logic_pipe_fifo.sv | 63 ++++++
 rtl/logic_pipe.sv | 87 ++++++++
 tb/tb_logic_pipe.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/logic_pipe_pkg.sv
// rtl/logic_pipe_pkg.sv - shared types, level width and per-bit combine function for logic_pipe
package logic_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_LEGACY = 2'd0,
    MODE_AND    = 2'd1,
    MODE_OR     = 2'd2,
    MODE_XORH   = 2'd3
  } mode_e;

  localparam int FIFO_DEPTH_DEFAULT = 4;
  localparam int LEVEL_W_DEFAULT    = $clog2(FIFO_DEPTH_DEFAULT) + 1;

  // Occupancy needs one extra bit so that "full" (== depth) is representable.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Operates on one bit; lanes are purely bitwise so the top applies it per bit.
  function automatic logic lane_combine(input mode_e m, input logic a, input logic b,
                                        input logic d);
    logic r;
    case (m)
      MODE_AND:  r = a & b;
      MODE_OR:   r = a | b;
      MODE_XORH: r = b ^ d;
      default:   r = (a & b) | (b ^ d);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_pipe_if.sv
// rtl/logic_pipe_if.sv - input/output handshake bundle of logic_pipe; out_par present with PARITY_EN
interface logic_pipe_if
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LANES   = 2,
  parameter int LEVEL_W = LEVEL_W_DEFAULT
);
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               mode;
  logic [LANES*WIDTH-1:0]   pi1;
  logic [LANES*WIDTH-1:0]   pi2;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*WIDTH-1:0]   po1;
  logic [LANES*WIDTH-1:0]   po2;
  logic [LANES*WIDTH-1:0]   po2_n;
  logic [LEVEL_W-1:0]       level;
`ifdef PARITY_EN
  logic [LANES-1:0]         out_par;
`endif

  modport master (
    output in_valid, mode, pi1, pi2, out_ready,
    input  in_ready, out_valid, po1, po2, po2_n, level
`ifdef PARITY_EN
    , input out_par
`endif
  );

  modport slave (
    input  in_valid, mode, pi1, pi2, out_ready,
    output in_ready, out_valid, po1, po2, po2_n, level
`ifdef PARITY_EN
    , output out_par
`endif
  );
endinterface

// File: rtl/logic_pipe_fifo.sv
// rtl/logic_pipe_fifo.sv - synchronous FIFO with registered head output and occupancy count
module logic_pipe_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          sys_clk,
  input  logic          sys_rstb,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [DW-1:0] head_q, head_d;
  logic          do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = head_q;
  assign level_o = level_q;

  // Next pointers/level; head register is preloaded so the head is a flop, and holds when empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
    head_d   = head_q;
    if (level_d != '0) begin
      if (do_push && (wr_ptr_q == rd_ptr_d)) head_d = push_data_i;
      else                                   head_d = mem_q[rd_ptr_d];
    end
  end

  // Control state; reset discards every buffered entry at once.
  always_ff @(posedge sys_clk) begin
    if (!sys_rstb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  // Storage array; contents are only read once written, so no reset needed.
  always_ff @(posedge sys_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/logic_pipe.sv
// rtl/logic_pipe.sv - handshaked per-lane boolean combine stage with output FIFO; option PARITY_EN adds out_par
module logic_pipe
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LANES      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          sys_clk,
  input  logic          sys_rstb,
  logic_pipe_if.slave   bus
);
  localparam int N  = LANES * WIDTH;
  localparam int LW = level_width(FIFO_DEPTH);
`ifdef PARITY_EN
  localparam int DW = 2 * N + LANES;
`else
  localparam int DW = 2 * N;
`endif

  logic [N-1:0]  hist_q, hist_d, last_res_q, last_res_d, res;
  logic [DW-1:0] push_data, head;
  logic          accept, full, empty;

  // No ready-through: a pop in the same cycle never frees a slot for a push while full.
  assign bus.in_ready = !full;
  assign accept       = bus.in_valid && !full;

  // Combine each bit with its lane's history bit; bitwise, so lanes never interact.
  always_comb begin
    res = '0;
    for (int j = 0; j < N; j++) begin
      res[j] = lane_combine(mode_e'(bus.mode), bus.pi1[j], bus.pi2[j], hist_q[j]);
    end
  end

`ifdef PARITY_EN
  logic [LANES-1:0] par;
  // Lane parity is computed at accept time and travels with the entry.
  always_comb begin
    par = '0;
    for (int l = 0; l < LANES; l++) par[l] = ^res[l*WIDTH +: WIDTH];
  end
  assign push_data   = {par, res, last_res_q};
  assign bus.out_par = head[DW-1 -: LANES];
`else
  assign push_data = {res, last_res_q};
`endif

  // History and previous result advance only on an accepted beat.
  always_comb begin
    hist_d     = accept ? bus.pi1 : hist_q;
    last_res_d = accept ? res     : last_res_q;
  end

  // History registers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rstb) begin
      hist_q     <= '0;
      last_res_q <= '0;
    end else begin
      hist_q     <= hist_d;
      last_res_q <= last_res_d;
    end
  end

  logic_pipe_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH), .LW(LW)) u_fifo (
    .sys_clk     (sys_clk),
    .sys_rstb    (sys_rstb),
    .push_i      (accept),
    .push_data_i (push_data),
    .pop_i       (bus.out_ready),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .level_o     (bus.level)
  );

  assign bus.out_valid = !empty;
  assign bus.po1       = head[2*N-1:N];
  assign bus.po2       = head[N-1:0];
  assign bus.po2_n     = ~head[N-1:0];

  // Producer must hold the beat steady while it is stalled.
  assert property (@(posedge sys_clk) disable iff (!sys_rstb)
    (bus.in_valid && !bus.in_ready) |=> (!bus.in_valid || $stable({bus.mode, bus.pi1, bus.pi2})));
endmodule

// File: tb/tb_logic_pipe.sv
// tb/tb_logic_pipe.sv - directed self-checking bench for logic_pipe (WIDTH=8, LANES=2, FIFO_DEPTH=4)
module tb_logic_pipe;
  logic clk = 1'b0;
  logic rstb;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  logic_pipe_if #(.WIDTH(8), .LANES(2), .LEVEL_W(3)) bus ();

  logic_pipe #(.WIDTH(8), .LANES(2), .FIFO_DEPTH(4)) dut (
    .sys_clk  (clk),
    .sys_rstb (rstb),
    .bus      (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.pi1      = a;
    bus.pi2      = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  logic [15:0] bp_data [5];
  logic [15:0] sweep_exp [4];

  initial begin
    rstb          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.mode      = 2'd0;
    bus.pi1       = '0;
    bus.pi2       = '0;
    tick();
    tick();
    check("rst_level", bus.level, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_po1", bus.po1, 0);
    check("rst_po2", bus.po2, 0);
    check("rst_po2_n", bus.po2_n, 16'hFFFF);
`ifdef PARITY_EN
    check("rst_out_par", bus.out_par, 0);
`endif
    rstb = 1'b1;
    tick();

    // LEGACY beats, consumer stalled
    send(2'd0, 16'h00F0, 16'h0F0F);
    check("leg1_valid", bus.out_valid, 1);
    check("leg1_po1", bus.po1, 16'h0F0F);
    check("leg1_po2", bus.po2, 16'h0000);
    send(2'd0, 16'h0000, 16'h00FF);
    check("leg2_level", bus.level, 2);
    bus.out_ready = 1'b1;
    tick();
    check("leg2_po1", bus.po1, 16'h000F);
    check("leg2_po2", bus.po2, 16'h0F0F);
    check("leg2_po2_n", bus.po2_n, 16'hF0F0);
    tick();
    check("leg_drain_level", bus.level, 0);
    check("leg_drain_valid", bus.out_valid, 0);

    // Mode sweep: prime hist=0x00FF (legacy with pi2=0 yields old hist), then mode beat
    sweep_exp[1] = 16'h0A50;
    sweep_exp[2] = 16'hAFF5;
    sweep_exp[3] = 16'h0F0F;
    for (int m = 1; m < 4; m++) begin
      send(2'd0, 16'h00FF, 16'h0000);
      send(2'(m), 16'hAA55, 16'h0FF0);
      check($sformatf("sweep%0d_po1", m), bus.po1, sweep_exp[m]);
      check($sformatf("sweep%0d_po2", m), bus.po2, (m == 1) ? 16'h0000 : 16'hAA55);
      check($sformatf("sweep%0d_level", m), bus.level, 1);
    end
    tick();
    check("sweep_drain", bus.level, 0);

    // Backpressure: five beats offered, four accepted
    bus.out_ready = 1'b0;
    bp_data[0] = 16'h1111; bp_data[1] = 16'h2222; bp_data[2] = 16'h3333;
    bp_data[3] = 16'h4444; bp_data[4] = 16'h5555;
    bus.mode = 2'd2;
    bus.pi2  = 16'h0000;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.pi1 = bp_data[k];
      tick();
    end
    check("bp_level_full", bus.level, 4);
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_head", bus.po1, 16'h1111);
    bus.out_ready = 1'b1;
    tick();
    check("bp_no_push_full", bus.level, 3);
    check("bp_pop1", bus.po1, 16'h2222);
    tick();
    bus.in_valid = 1'b0;
    check("bp_push_pop_level", bus.level, 3);
    check("bp_pop2", bus.po1, 16'h3333);
    tick();
    check("bp_pop3", bus.po1, 16'h4444);
    tick();
    check("bp_pop4", bus.po1, 16'h5555);
    check("bp_pop4_po2", bus.po2, 16'h4444);
    tick();
    check("bp_empty", bus.level, 0);

    // Steady state XORH stream with a gap; hist must hold across the gap
    send(2'd3, 16'h1234, 16'h0000);
    check("ss_a_po1", bus.po1, 16'h5555);
    check("ss_a_level", bus.level, 1);
    send(2'd3, 16'h00FF, 16'hFFFF);
    check("ss_b_po1", bus.po1, 16'hEDCB);
    check("ss_b_level", bus.level, 1);
    tick();
    tick();
    check("ss_gap_valid", bus.out_valid, 0);
    send(2'd3, 16'h0000, 16'h0F0F);
    check("ss_c_po1", bus.po1, 16'h0FF0);
    check("ss_c_po2", bus.po2, 16'hEDCB);
    tick();

    // Reset mid-stream with three entries buffered
    bus.out_ready = 1'b0;
    send(2'd1, 16'hFFFF, 16'h1111);
    send(2'd1, 16'hFFFF, 16'h2222);
    send(2'd1, 16'hFFFF, 16'h3333);
    check("mid_level3", bus.level, 3);
    rstb = 1'b0;
    tick();
    check("mid_rst_level", bus.level, 0);
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_po2_n", bus.po2_n, 16'hFFFF);
    rstb = 1'b1;
    tick();
    // hist cleared: legacy with pi1=0 gives pi2
    bus.out_ready = 1'b1;
    send(2'd0, 16'h0000, 16'h00F0);
    check("post_rst_po1", bus.po1, 16'h00F0);
    check("post_rst_po2", bus.po2, 16'h0000);
    send(2'd0, 16'h0000, 16'h0703);
    check("par_po1", bus.po1, 16'h0703);
`ifdef PARITY_EN
    check("par_bits", bus.out_par, 2'b10);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
